imem_pipelined: RTL and testbench

Parametrised successor to the single-cycle instruction memory. Word-addressed instruction ROM/RAM with a valid/ready fetch interface, configurable read latency, a program-load write port and fault reporting. It sits between the fetch stage and the core, so a pipelined or multi-cycle core can fetch with backpressure and redirect flushes.

---
 rtl/imem_pkg.sv | 19 +
 rtl/imem_if.sv | 28 ++
 rtl/imem_pipe_stage.sv | 29 ++
 rtl/imem_pipelined.sv | 86 ++++++++
 tb/tb_imem_pipelined.sv | 270 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/imem_pkg.sv
// Shared types and constants for the pipelined instruction memory.
package imem_pkg;

   localparam logic [31:0] NOP_WORD = 32'h0000_0013;

   typedef enum logic [1:0] {
      FAULT_NONE     = 2'd0,
      FAULT_MISALIGN = 2'd1,
      FAULT_RANGE    = 2'd2
   } fault_e;

   typedef struct packed {
      logic        valid;
      logic [31:0] addr;
      logic [31:0] inst;
      fault_e      fault;
   } imem_stage_t;

endpackage

// File: rtl/imem_if.sv
// Fetch request/response, flush and program-load signals of the instruction memory.
interface imem_if;
   import imem_pkg::*;

   logic        req_valid;
   logic        req_ready;
   logic [31:0] req_addr;
   logic        flush;
   logic        rsp_valid;
   logic        rsp_ready;
   logic [31:0] rsp_inst;
   logic [31:0] rsp_addr;
   fault_e      rsp_fault;
   logic        ld_en;
   logic [31:0] ld_addr;
   logic [31:0] ld_data;

   modport master (
      output req_valid, req_addr, flush, rsp_ready, ld_en, ld_addr, ld_data,
      input  req_ready, rsp_valid, rsp_inst, rsp_addr, rsp_fault
   );

   modport slave (
      input  req_valid, req_addr, flush, rsp_ready, ld_en, ld_addr, ld_data,
      output req_ready, rsp_valid, rsp_inst, rsp_addr, rsp_fault
   );

endinterface

// File: rtl/imem_pipe_stage.sv
// One fetch pipeline stage: holds {valid, addr, inst, fault}; flush drops the valid bit.
module imem_pipe_stage
   import imem_pkg::*;
#(
   parameter logic [31:0] RST_INST = NOP_WORD
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        i_en,
   input  logic        i_flush,
   input  imem_stage_t i_d,
   output imem_stage_t o_q
);

   imem_stage_t r_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_q <= '{valid: 1'b0, addr: 32'd0, inst: RST_INST, fault: FAULT_NONE};
      end else if (i_flush) begin
         r_q.valid <= 1'b0;
      end else if (i_en) begin
         r_q <= i_d;
      end
   end

   assign o_q = r_q;

endmodule

// File: rtl/imem_pipelined.sv
// Word-addressed instruction memory with LATENCY-deep valid/ready fetch pipeline,
// program-load write port, flush and misalign/range fault reporting.
module imem_pipelined #(
   parameter int unsigned DEPTH    = 1024,
   parameter int unsigned LATENCY  = 1,
   parameter logic [31:0] NOP_WORD = imem_pkg::NOP_WORD
) (
   input logic   clk,
   input logic   rst_n,
   imem_if.slave bus
);
   import imem_pkg::*;

   localparam int unsigned AW = $clog2(DEPTH);

   // Contents survive reset; only time zero sees the NOP fill.
   logic [31:0] r_mem [DEPTH] = '{default: NOP_WORD};

   logic                      w_adv;
   logic [31:0]               w_req_word;
   logic [31:0]               w_ld_word;
   fault_e                    w_fault;
   imem_stage_t               w_s1;
   imem_stage_t [LATENCY-1:0] w_d;
   imem_stage_t [LATENCY-1:0] w_q;
   logic        [LATENCY-1:0] w_fl;

   // Whole pipe moves together; flush always frees the input slot.
   assign w_adv         = !w_q[LATENCY-1].valid || bus.rsp_ready || bus.flush;
   assign bus.req_ready = w_adv;

   assign w_req_word = bus.req_addr >> 2;
   assign w_ld_word  = bus.ld_addr >> 2;

   always_comb begin
      w_fault = FAULT_NONE;
      if (bus.req_addr[1:0] != 2'b00) begin
         w_fault = FAULT_MISALIGN;
      end else if (w_req_word >= 32'(DEPTH)) begin
         w_fault = FAULT_RANGE;
      end
   end

   // Stage-1 payload; the array is only indexed for fault-free requests.
   always_comb begin
      w_s1 = '{valid: bus.req_valid, addr: bus.req_addr, inst: NOP_WORD, fault: w_fault};
      if (w_fault == FAULT_NONE) begin
         w_s1.inst = r_mem[w_req_word[AW-1:0]];
      end
   end

   // Write lands at the edge, so a same-cycle fetch still sees the old word.
   always_ff @(posedge clk) begin
      if (bus.ld_en && (w_ld_word < 32'(DEPTH))) begin
         r_mem[w_ld_word[AW-1:0]] <= bus.ld_data;
      end
   end

   for (genvar g = 0; g < LATENCY; g++) begin : g_stage
      // Stage 1 ignores flush so a request in the flush cycle survives.
      if (g == 0) begin : g_head
         assign w_d[g]  = w_s1;
         assign w_fl[g] = 1'b0;
      end else begin : g_tail
         assign w_d[g]  = w_q[g-1];
         assign w_fl[g] = bus.flush;
      end

      imem_pipe_stage #(
         .RST_INST (NOP_WORD)
      ) u_stage (
         .clk     (clk),
         .rst_n   (rst_n),
         .i_en    (w_adv),
         .i_flush (w_fl[g]),
         .i_d     (w_d[g]),
         .o_q     (w_q[g])
      );
   end

   assign bus.rsp_valid = w_q[LATENCY-1].valid;
   assign bus.rsp_inst  = w_q[LATENCY-1].inst;
   assign bus.rsp_addr  = w_q[LATENCY-1].addr;
   assign bus.rsp_fault = w_q[LATENCY-1].fault;

endmodule

// File: tb/tb_imem_pipelined.sv
// Directed bench for imem_pipelined at LATENCY 1, 2 and 3 with a per-instance response scoreboard.
module tb_imem_pipelined;
   import imem_pkg::*;

   localparam int unsigned DEPTH = 1024;
   localparam int unsigned NI    = 3;
   localparam logic [31:0] NOP   = 32'h0000_0013;

   typedef struct {
      logic [31:0] addr;
      logic [31:0] inst;
      logic [1:0]  fault;
      int unsigned acc;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst_n;
   int          total = 0;
   int          bad   = 0;
   int unsigned cyc   = 0;

   logic [NI-1:0]       rv, fl, rr, le;
   logic [NI-1:0][31:0] ra, la, ldd;
   logic [NI-1:0]       o_rdy, o_v;
   logic [NI-1:0][31:0] o_i, o_a;
   logic [NI-1:0][1:0]  o_f;

   always #5 clk = ~clk;
   always @(posedge clk) cyc++;

   imem_if bus [NI] ();

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [1:0] exp_fault(input logic [31:0] a);
      if (a[1:0] != 2'b00) return 2'd1;
      if (a[31:2] >= 30'(DEPTH)) return 2'd2;
      return 2'd0;
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   for (genvar g = 0; g < NI; g++) begin : g_dut
      imem_pipelined #(
         .DEPTH    (DEPTH),
         .LATENCY  (g + 1),
         .NOP_WORD (NOP)
      ) u_dut (
         .clk   (clk),
         .rst_n (rst_n),
         .bus   (bus[g])
      );

      assign bus[g].req_valid = rv[g];
      assign bus[g].req_addr  = ra[g];
      assign bus[g].flush     = fl[g];
      assign bus[g].rsp_ready = rr[g];
      assign bus[g].ld_en     = le[g];
      assign bus[g].ld_addr   = la[g];
      assign bus[g].ld_data   = ldd[g];
      assign o_rdy[g] = bus[g].req_ready;
      assign o_v[g]   = bus[g].rsp_valid;
      assign o_i[g]   = bus[g].rsp_inst;
      assign o_a[g]   = bus[g].rsp_addr;
      assign o_f[g]   = bus[g].rsp_fault;

      exp_t        sb [$];
      exp_t        e, p;
      logic [31:0] mdl [DEPTH];
      logic        stall = 1'b0;
      logic [31:0] h_i, h_a;
      logic [1:0]  h_f;
      int unsigned n_rsp  = 0;
      int unsigned n_pend = 0;

      initial for (int i = 0; i < int'(DEPTH); i++) mdl[i] = NOP;

      // Inputs are stable around the negedge, so this sees exactly what the next posedge will.
      always @(negedge clk or negedge rst_n) begin
         if (!rst_n) begin
            sb.delete();
            stall = 1'b0;
         end else begin
            if (stall) begin
               chk($sformatf("u%0d hold_valid", g), 64'(o_v[g]), 64'(1));
               chk($sformatf("u%0d hold_inst", g), 64'(o_i[g]), 64'(h_i));
               chk($sformatf("u%0d hold_addr", g), 64'(o_a[g]), 64'(h_a));
               chk($sformatf("u%0d hold_fault", g), 64'(o_f[g]), 64'(h_f));
            end
            if (fl[g]) begin
               sb.delete();
            end else if (o_v[g] && rr[g]) begin
               chk($sformatf("u%0d spurious_rsp", g), 64'(sb.size() != 0), 64'(1));
               if (sb.size() != 0) begin
                  e = sb.pop_front();
                  chk($sformatf("u%0d inst@%0h", g, e.addr), 64'(o_i[g]), 64'(e.inst));
                  chk($sformatf("u%0d addr", g), 64'(o_a[g]), 64'(e.addr));
                  chk($sformatf("u%0d fault@%0h", g, e.addr), 64'(o_f[g]), 64'(e.fault));
                  chk($sformatf("u%0d min_latency", g), 64'((cyc - e.acc) >= 32'(g + 1)), 64'(1));
                  n_rsp++;
               end
            end
            if (rv[g] && o_rdy[g]) begin
               p.addr  = ra[g];
               p.fault = exp_fault(ra[g]);
               p.inst  = (p.fault != 2'd0) ? NOP : mdl[ra[g][11:2]];
               p.acc   = cyc;
               sb.push_back(p);
            end
            if (le[g] && (la[g][31:2] < 30'(DEPTH))) mdl[la[g][11:2]] = ldd[g];
            stall = o_v[g] && !rr[g] && !fl[g];
            h_i = o_i[g];
            h_a = o_a[g];
            h_f = o_f[g];
         end
         n_pend = sb.size();
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      int unsigned sent, c, base;
      logic        rdy, saw_block;

      rst_n = 1'b0;
      rv = '0; fl = '0; rr = '1; le = '0; ra = '0; la = '0; ldd = '0;
      repeat (2) step();
      for (int k = 0; k < int'(NI); k++) begin
         chk($sformatf("u%0d reset rsp_valid", k), 64'(o_v[k]), 64'(0));
         chk($sformatf("u%0d reset rsp_inst", k), 64'(o_i[k]), 64'(NOP));
         chk($sformatf("u%0d reset rsp_addr", k), 64'(o_a[k]), 64'(0));
         chk($sformatf("u%0d reset rsp_fault", k), 64'(o_f[k]), 64'(0));
      end
      rst_n = 1'b1;
      step();

      // LATENCY=1: load two words, then fetch them back to back
      le[0] = 1'b1; la[0] = 32'h0; ldd[0] = 32'h0050_0093; step();
      la[0] = 32'h4; ldd[0] = 32'h0060_0113; step();
      le[0] = 1'b0;
      rv[0] = 1'b1; ra[0] = 32'h0; step();
      chk("l1 first rsp_valid", 64'(o_v[0]), 64'(1));
      chk("l1 first rsp_inst", 64'(o_i[0]), 64'(32'h0050_0093));
      ra[0] = 32'h4; step();
      chk("l1 second rsp_inst", 64'(o_i[0]), 64'(32'h0060_0113));
      chk("l1 second rsp_addr", 64'(o_a[0]), 64'(32'h4));
      chk("l1 second rsp_fault", 64'(o_f[0]), 64'(0));
      rv[0] = 1'b0; step();
      chk("l1 drained rsp_valid", 64'(o_v[0]), 64'(0));

      // Faults: misaligned, past the end, last word, misaligned beats range, high bits no wrap
      rv[0] = 1'b1; ra[0] = 32'h2; step();
      chk("misalign fault", 64'(o_f[0]), 64'(1));
      chk("misalign inst", 64'(o_i[0]), 64'(NOP));
      ra[0] = 32'h1000; step();
      chk("range fault", 64'(o_f[0]), 64'(2));
      chk("range inst", 64'(o_i[0]), 64'(NOP));
      ra[0] = 32'hFFC; step();
      chk("last word fault", 64'(o_f[0]), 64'(0));
      ra[0] = 32'h1002; step();
      chk("misalign priority", 64'(o_f[0]), 64'(1));
      ra[0] = 32'hFFFF_FFFC; step();
      chk("high addr no wrap", 64'(o_f[0]), 64'(2));
      rv[0] = 1'b0; step();

      // Read-before-write on a same-cycle load and fetch of word 0x8
      le[0] = 1'b1; la[0] = 32'h8; ldd[0] = 32'hDEAD_BEEF;
      rv[0] = 1'b1; ra[0] = 32'h8; step();
      le[0] = 1'b0;
      chk("rbw old word", 64'(o_i[0]), 64'(NOP));
      step();
      chk("rbw refetch new word", 64'(o_i[0]), 64'(32'hDEAD_BEEF));
      rv[0] = 1'b0; step();

      // LATENCY=3: eight back-to-back fetches with a three-cycle consumer stall
      for (int k = 0; k < 8; k++) begin
         le[2] = 1'b1; la[2] = 32'(4 * k); ldd[2] = 32'h1000 + 32'(k); step();
      end
      le[2] = 1'b0;
      base = g_dut[2].n_rsp;
      sent = 0; c = 0; saw_block = 1'b0;
      while (sent < 8 && c < 40) begin
         rv[2] = 1'b1;
         ra[2] = 32'(4 * sent);
         rr[2] = !(c >= 5 && c <= 7);
         #1;
         rdy = o_rdy[2];
         if (!rdy) saw_block = 1'b1;
         step();
         if (rdy) sent++;
         c++;
      end
      rv[2] = 1'b0; rr[2] = 1'b1;
      chk("l3 all requests accepted", 64'(sent), 64'(8));
      chk("l3 req_ready dropped on stall", 64'(saw_block), 64'(1));
      for (int i = 0; i < 40 && g_dut[2].n_rsp < base + 8; i++) step();
      chk("l3 response count", 64'(g_dut[2].n_rsp - base), 64'(8));
      chk("l3 nothing pending", 64'(g_dut[2].n_pend), 64'(0));

      // LATENCY=3: exact latency of an isolated fetch
      rv[2] = 1'b1; ra[2] = 32'h1C; step();
      rv[2] = 1'b0;
      chk("l3 lat cycle1", 64'(o_v[2]), 64'(0));
      step();
      chk("l3 lat cycle2", 64'(o_v[2]), 64'(0));
      step();
      chk("l3 lat cycle3 valid", 64'(o_v[2]), 64'(1));
      chk("l3 lat cycle3 inst", 64'(o_i[2]), 64'(32'h0000_1007));
      step();

      // LATENCY=2: flush with two in flight plus a new request in the same cycle
      base = g_dut[1].n_rsp;
      rv[1] = 1'b1; ra[1] = 32'h0; step();
      ra[1] = 32'h4; step();
      chk("l2 pre-flush rsp_valid", 64'(o_v[1]), 64'(1));
      fl[1] = 1'b1; ra[1] = 32'h40; step();
      fl[1] = 1'b0; rv[1] = 1'b0;
      chk("l2 after flush rsp_valid", 64'(o_v[1]), 64'(0));
      step();
      chk("l2 redirect rsp_valid", 64'(o_v[1]), 64'(1));
      chk("l2 redirect rsp_addr", 64'(o_a[1]), 64'(32'h40));
      step();
      chk("l2 redirect drained", 64'(o_v[1]), 64'(0));
      chk("l2 only one response", 64'(g_dut[1].n_rsp - base), 64'(1));

      // LATENCY=3: asynchronous reset mid-stream
      rv[2] = 1'b1; ra[2] = 32'h0;
      repeat (4) step();
      chk("rst pre rsp_valid", 64'(o_v[2]), 64'(1));
      #2 rst_n = 1'b0;
      #1;
      chk("rst immediate rsp_valid", 64'(o_v[2]), 64'(0));
      chk("rst immediate rsp_inst", 64'(o_i[2]), 64'(NOP));
      rv[2] = 1'b0;
      repeat (2) step();
      rst_n = 1'b1;
      for (int i = 0; i < 6; i++) begin
         step();
         chk($sformatf("rst quiet cycle %0d", i), 64'(o_v[2]), 64'(0));
      end
      rv[2] = 1'b1; ra[2] = 32'h8; step();
      rv[2] = 1'b0;
      repeat (2) step();
      chk("rst retained valid", 64'(o_v[2]), 64'(1));
      chk("rst retained inst", 64'(o_i[2]), 64'(32'h0000_1002));
      repeat (2) step();

      chk("u0 final pending", 64'(g_dut[0].n_pend), 64'(0));
      chk("u1 final pending", 64'(g_dut[1].n_pend), 64'(0));
      chk("u2 final pending", 64'(g_dut[2].n_pend), 64'(0));

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
